// File: rtl/rca_byte_sequencer.sv
// Multi-byte add/subtract sequencer: one shared 8-bit ripple-carry adder,
// one byte per clock (LSB first), with the inter-byte carry held in a register.
// Latency: NBYTES cycles from the accept edge to done; one op per NBYTES+2 cycles.
// Backpressure: start is accepted only while ready (IDLE); it is ignored in RUN/DONE.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, op_sub, a, b  request handshake and operands (sampled on accept)
//   ready, done          idle indicator, one-cycle completion pulse
//   sum, c_out, ovf      wide result, carry/no-borrow, signed overflow

// 8-bit ripple-carry adder cell, purely combinational.
module rca_8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] s_o,
    output logic       c_o
);
    logic [8:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[8];
endmodule

module rca_byte_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op_sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  c_out,
    output logic                  ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            op_sub_q, op_sub_d;
    logic            cy_q, cy_d;
    logic            c_out_q, c_out_d;
    logic            ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      s_byte;
    logic            add_co;
    logic            last;

    // Select operand byte idx; B is inverted for subtraction (carry-in
    // of 1 on byte 0 completes the two's complement).
    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (idx_q == IW'(k)) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8] ^ {8{op_sub_q}};
            end
        end
    end

    assign last = (idx_q == IW'(NBYTES - 1));

    rca_8 u_rca (
        .a_i (a_byte),
        .b_i (b_byte),
        .c_i (cy_q),
        .s_o (s_byte),
        .c_o (add_co)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_sub_d = op_sub_q;
        cy_d     = cy_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_sub_d = op_sub;
                    cy_d     = op_sub;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (idx_q == IW'(k)) begin
                        sum_d[8*k +: 8] = s_byte;
                    end
                end
                cy_d  = add_co;
                idx_d = idx_q + IW'(1);
                if (last) begin
                    c_out_d = add_co;
                    // On the top byte a_byte[7] is the sign of A and
                    // b_byte[7] the sign of the (possibly inverted) B.
                    ovf_d   = (a_byte[7] == b_byte[7]) && (s_byte[7] != a_byte[7]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_sub_q <= 1'b0;
            cy_q     <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_sub_q <= op_sub_d;
            cy_q     <= cy_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_rca_byte_sequencer.sv
// Scoreboard bench for rca_byte_sequencer (NBYTES=4): directed vectors push
// expected results at issue; a negedge monitor pops and compares on done.
module tb_rca_byte_sequencer;
    localparam int NB = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          op_sub;
    logic [31:0]   a;
    logic [31:0]   b;
    logic          ready;
    logic          done;
    logic [31:0]   sum;
    logic          c_out;
    logic          ovf;

    rca_byte_sequencer #(.NBYTES(NB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .sum    (sum),
        .c_out  (c_out),
        .ovf    (ovf)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    endtask

    task automatic fail_now(input string nm);
        n_total++;
        $display("FAIL %s: got timeout/unexpected event expected none", nm);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum",   64'(sum),   64'(e.s));
                chk("c_out", 64'(c_out), 64'(e.c));
                chk("ovf",   64'(ovf),   64'(e.o));
                chk("done_latency", 64'(cyc - e.acc), 64'(NB));
            end
        end
    end

    // Issue one operation; returns at the negedge right after the accept edge.
    task automatic issue(input logic sub, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] es, input logic ec, input logic eo);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            fail_now("issue_wait_ready");
            return;
        end
        start  = 1'b1;
        op_sub = sub;
        a      = av;
        b      = bv;
        e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        op_sub = 1'($urandom);
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        int lo;
        int k;
        int acc0;
        int acc1;
        int n;
        logic [31:0] hs_a [2];
        logic [31:0] hs_b [2];
        logic        hs_op[2];
        logic [31:0] hs_s [2];
        logic        hs_c [2];
        logic        hs_o [2];

        start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_sum",   64'(sum),   64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_ovf",   64'(ovf),   64'd0);
        rst_n = 1'b1;

        // Carry wrap, plus ready-low window.
        issue(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        lo = 0;
        while (!ready && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 64'(lo), 64'd5);
        drain();

        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        issue(1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0);
        drain();

        // Start held high; operands scrambled whenever not idle.
        hs_a[0] = 32'h0000_FFFF; hs_b[0] = 32'h0000_0001; hs_op[0] = 1'b0;
        hs_s[0] = 32'h0001_0000; hs_c[0] = 1'b0; hs_o[0] = 1'b0;
        hs_a[1] = 32'h0000_0010; hs_b[1] = 32'h0000_0010; hs_op[1] = 1'b1;
        hs_s[1] = 32'h0000_0000; hs_c[1] = 1'b1; hs_o[1] = 1'b0;
        k = 0; acc0 = 0; acc1 = 0; n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (k == 2) begin
                start = 1'b0;
                break;
            end else if (ready) begin
                exp_t e;
                start  = 1'b1;
                op_sub = hs_op[k];
                a      = hs_a[k];
                b      = hs_b[k];
                e.s = hs_s[k]; e.c = hs_c[k]; e.o = hs_o[k]; e.acc = cyc + 1;
                exp_q.push_back(e);
                if (k == 0) acc0 = cyc + 1;
                else        acc1 = cyc + 1;
                k++;
            end else begin
                start  = 1'b1;
                op_sub = 1'($urandom);
                a      = $urandom;
                b      = $urandom;
            end
        end
        start = 1'b0;
        if (k != 2) fail_now("handshake_accepts");
        else        chk("reaccept_spacing", 64'(acc1 - acc0), 64'd6);
        drain();

        // Reset two cycles into RUN: abandon, then a clean add.
        @(negedge clk);
        while (!ready) @(negedge clk);
        start = 1'b1; op_sub = 1'b0; a = 32'hAAAA_AAAA; b = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_done",  64'(done),  64'd0);
        chk("midrst_sum",   64'(sum),   64'd0);
        chk("midrst_c_out", 64'(c_out), 64'd0);
        chk("midrst_ovf",   64'(ovf),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
        drain();
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
